// File: rtl/control_unit_seq.sv
// One-hot control sequencer for the 16-bit ASIP: fetch/decode, ALU handshake, flag branches, sticky error.
// Optional ALU acknowledge timeout is enabled by defining CU_ALU_TIMEOUT_EN.
module control_unit_seq #(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [OP_W-1:0] op,
  input  logic            ra,
  input  logic            start,
  input  logic            ack_alu,
  input  logic [3:0]      flags,
  output logic            finish,
  output logic            busy,
  output logic            alu_start,
  output logic [2:0]      alu_op,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [18:0]     c
);

  typedef enum logic [28:0] {
    S_IDLE    = 29'd1 << 0,  S_START  = 29'd1 << 1,  S_FETCH  = 29'd1 << 2,
    S_DECODE  = 29'd1 << 3,  S_LDR_OP = 29'd1 << 4,  S_LDR_X  = 29'd1 << 5,
    S_LDR_Y   = 29'd1 << 6,  S_LA_X   = 29'd1 << 7,  S_LA_Y   = 29'd1 << 8,
    S_LAGEN   = 29'd1 << 9,  S_LAWAIT = 29'd1 << 10, S_LMEM   = 29'd1 << 11,
    S_LWB     = 29'd1 << 12, S_STR_OP = 29'd1 << 13, S_STR_X  = 29'd1 << 14,
    S_STR_Y   = 29'd1 << 15, S_SA_X   = 29'd1 << 16, S_SA_Y   = 29'd1 << 17,
    S_SAGEN   = 29'd1 << 18, S_SAWAIT = 29'd1 << 19, S_SADDR  = 29'd1 << 20,
    S_SWR     = 29'd1 << 21, S_LI_OP  = 29'd1 << 22, S_SI_OP  = 29'd1 << 23,
    S_AEX     = 29'd1 << 24, S_AWAIT  = 29'd1 << 25, S_AWB    = 29'd1 << 26,
    S_BR_OP   = 29'd1 << 27, S_BR_TAKE = 29'd1 << 28
  } state_t;

  state_t      state_reg, state_next;
  logic        err_reg, err_next;
  logic [1:0]  code_reg, code_next;
  logic [2:0]  alu_op_reg, alu_op_next;
  logic        hi_zero;
  logic        br_cond;

  // Opcode bits above [5:0] must be zero for a legal instruction.
  if (OP_W > 6) begin : g_hi
    assign hi_zero = ~|op[OP_W-1:6];
  end else begin : g_nohi
    assign hi_zero = 1'b1;
  end

  always_comb begin
    case (op[2:0])
      3'b000:  br_cond = 1'b1;
      3'b001:  br_cond = flags[0];
      3'b010:  br_cond = ~flags[0];
      3'b011:  br_cond = flags[1];
      3'b100:  br_cond = flags[2];
      3'b101:  br_cond = flags[3];
      3'b110:  br_cond = ~flags[1];
      default: br_cond = ~flags[2];
    endcase
  end

`ifdef CU_ALU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             expired;
  assign expired = (cnt_reg == CNT_W'(TIMEOUT - 1));
`endif

  always_comb begin
    state_next  = state_reg;
    err_next    = err_reg;
    code_next   = code_reg;
    alu_op_next = alu_op_reg;
`ifdef CU_ALU_TIMEOUT_EN
    cnt_next    = cnt_reg;
`endif
    case (state_reg)
      S_IDLE: if (start) begin
        state_next = S_START;
        err_next   = 1'b0;
        code_next  = 2'b00;
      end
      S_START:  state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        if (!hi_zero) begin
          state_next = S_IDLE;
          err_next   = 1'b1;
          code_next  = 2'b01;
        end else begin
          casez (op[5:0])
            6'b000000: state_next = S_IDLE;
            6'b000001: state_next = S_LDR_OP;
            6'b000010: begin state_next = ra ? S_LA_Y : S_LA_X; alu_op_next = 3'b000; end
            6'b000011: state_next = S_STR_OP;
            6'b000100: begin state_next = ra ? S_SA_Y : S_SA_X; alu_op_next = 3'b000; end
            6'b000101: state_next = S_LI_OP;
            6'b000110: state_next = S_SI_OP;
            6'b001???: begin state_next = S_AEX; alu_op_next = op[2:0]; end
            6'b010???: state_next = S_BR_OP;
            default: begin
              state_next = S_IDLE;
              err_next   = 1'b1;
              code_next  = 2'b01;
            end
          endcase
        end
      end
      S_LDR_OP:           state_next = ra ? S_LDR_Y : S_LDR_X;
      S_STR_OP:           state_next = ra ? S_STR_Y : S_STR_X;
      S_LA_X, S_LA_Y:     state_next = S_LAGEN;
      S_SA_X, S_SA_Y:     state_next = S_SAGEN;
      S_LAGEN:            state_next = S_LAWAIT;
      S_SAGEN:            state_next = S_SAWAIT;
      S_AEX:              state_next = S_AWAIT;
      S_LMEM, S_LI_OP:    state_next = S_LWB;
      S_SADDR, S_SI_OP:   state_next = S_SWR;
      S_BR_OP:            state_next = br_cond ? S_BR_TAKE : S_FETCH;
      S_LAWAIT, S_SAWAIT, S_AWAIT: begin
        if (ack_alu) begin
          state_next = (state_reg == S_LAWAIT) ? S_LMEM :
                       (state_reg == S_SAWAIT) ? S_SADDR : S_AWB;
        end
`ifdef CU_ALU_TIMEOUT_EN
        else begin
          cnt_next = cnt_reg + 1'b1;
          if (expired) begin
            state_next = S_IDLE;
            err_next   = 1'b1;
            code_next  = 2'b10;
          end
        end
`endif
      end
      default:            state_next = S_FETCH;
    endcase
`ifdef CU_ALU_TIMEOUT_EN
    // Each launch state restarts the wait budget for the wait state it enters.
    if (state_reg == S_LAGEN || state_reg == S_SAGEN || state_reg == S_AEX)
      cnt_next = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_reg  <= S_IDLE;
      err_reg    <= 1'b0;
      code_reg   <= 2'b00;
      alu_op_reg <= 3'b000;
`ifdef CU_ALU_TIMEOUT_EN
      cnt_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      err_reg    <= err_next;
      code_reg   <= code_next;
      alu_op_reg <= alu_op_next;
`ifdef CU_ALU_TIMEOUT_EN
      cnt_reg    <= cnt_next;
`endif
    end
  end

  always_comb begin
    c = '0;
    case (state_reg)
      S_START:              c[0]  = 1'b1;
      S_FETCH:              c[1]  = 1'b1;
      S_DECODE:             c[2]  = 1'b1;
      S_LDR_OP, S_LI_OP, S_BR_OP: c[3] = 1'b1;
      S_LDR_X:              c[4]  = 1'b1;
      S_LDR_Y:              c[5]  = 1'b1;
      S_LA_X, S_SA_X:       c[6]  = 1'b1;
      S_LA_Y, S_SA_Y:       c[7]  = 1'b1;
      S_LAGEN, S_SAGEN:     c[8]  = 1'b1;
      S_LMEM:               c[9]  = 1'b1;
      S_LWB:                c[10] = 1'b1;
      S_STR_OP, S_SI_OP:    c[11] = 1'b1;
      S_STR_X:              c[12] = 1'b1;
      S_STR_Y:              c[13] = 1'b1;
      S_SADDR:              c[14] = 1'b1;
      S_SWR:                c[15] = 1'b1;
      S_AEX:                c[16] = 1'b1;
      S_AWB:                c[17] = 1'b1;
      S_BR_TAKE:            c[18] = 1'b1;
      default:              c     = '0;
    endcase
  end

  assign finish    = (state_reg == S_IDLE);
  assign busy      = ~finish;
  assign alu_start = (state_reg == S_LAGEN) || (state_reg == S_SAGEN) || (state_reg == S_AEX);
  assign alu_op    = alu_op_reg;
  assign err       = err_reg;
  assign err_code  = code_reg;

endmodule

// File: tb/tb_control_unit_seq.sv
// Directed self-checking bench for control_unit_seq (TIMEOUT=4; timeout steps run when CU_ALU_TIMEOUT_EN is defined).
module tb_control_unit_seq;

  logic        clk = 1'b0;
  logic        rst_b, ra, start, ack_alu;
  logic [5:0]  op;
  logic [3:0]  flags;
  logic        finish, busy, alu_start, err;
  logic [2:0]  alu_op;
  logic [1:0]  err_code;
  logic [18:0] c;

  int checks = 0;
  int passes = 0;

  control_unit_seq #(.OP_W(6), .TIMEOUT(4)) dut (
    .clk(clk), .rst_b(rst_b), .op(op), .ra(ra), .start(start), .ack_alu(ack_alu),
    .flags(flags), .finish(finish), .busy(busy), .alu_start(alu_start), .alu_op(alu_op),
    .err(err), .err_code(err_code), .c(c)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [18:0] cb(input int n);
    logic [18:0] one;
    one = 19'd1;
    return one << n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Step one clock, then check the strobe vector and finish/busy/alu_start.
  task automatic step(input string tag, input logic [18:0] exp_c, input logic exp_fin,
                      input logic exp_as);
    tick();
    chk({tag, ".c"}, 32'(c), 32'(exp_c));
    chk({tag, ".finish"}, 32'(finish), 32'(exp_fin));
    chk({tag, ".busy"}, 32'(busy), 32'(!exp_fin));
    chk({tag, ".alu_start"}, 32'(alu_start), 32'(exp_as));
  endtask

  initial begin
    rst_b = 1'b0; start = 1'b0; op = 6'd0; ra = 1'b0; ack_alu = 1'b0; flags = 4'd0;
    tick(); tick();
    chk("rst.c", 32'(c), 32'd0);
    chk("rst.finish", 32'(finish), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.alu_start", 32'(alu_start), 32'd0);
    chk("rst.alu_op", 32'(alu_op), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.err_code", 32'(err_code), 32'd0);
    rst_b = 1'b1;
    step("idle_hold", 19'd0, 1'b1, 1'b0);

    $display("tx LDR ra=1");
    op = 6'b000001; ra = 1'b1; start = 1'b1;
    step("ldr.start", cb(0), 1'b0, 1'b0);
    start = 1'b0;
    step("ldr.fetch", cb(1), 1'b0, 1'b0);
    step("ldr.decode", cb(2), 1'b0, 1'b0);
    step("ldr.op", cb(3), 1'b0, 1'b0);
    step("ldr.y", cb(5), 1'b0, 1'b0);
    step("ldr.fetch2", cb(1), 1'b0, 1'b0);

    $display("tx ALU op=001011 ack on 3rd wait");
    op = 6'b001011;
    step("alu.decode", cb(2), 1'b0, 1'b0);
    step("alu.aex", cb(16), 1'b0, 1'b1);
    chk("alu.aex.alu_op", 32'(alu_op), 32'd3);
    ack_alu = 1'b1;
    op = 6'b000000;  // ack outside a wait state and IR change must both be ignored
    step("alu.wait1", 19'd0, 1'b0, 1'b0);
    ack_alu = 1'b0;
    chk("alu.wait1.alu_op", 32'(alu_op), 32'd3);
    step("alu.wait2", 19'd0, 1'b0, 1'b0);
    step("alu.wait3", 19'd0, 1'b0, 1'b0);
    chk("alu.wait3.alu_op", 32'(alu_op), 32'd3);
    ack_alu = 1'b1;
    step("alu.awb", cb(17), 1'b0, 1'b0);
    ack_alu = 1'b0;
    step("alu.fetch", cb(1), 1'b0, 1'b0);

    $display("tx BR Z taken");
    op = 6'b010001; flags = 4'b0001;
    step("brt.decode", cb(2), 1'b0, 1'b0);
    step("brt.op", cb(3), 1'b0, 1'b0);
    step("brt.take", cb(18), 1'b0, 1'b0);
    step("brt.fetch", cb(1), 1'b0, 1'b0);

    $display("tx BR Z not taken");
    flags = 4'b0000;
    step("brn.decode", cb(2), 1'b0, 1'b0);
    step("brn.op", cb(3), 1'b0, 1'b0);
    step("brn.fetch", cb(1), 1'b0, 1'b0);

    $display("tx BR !C with C=0 taken");
    op = 6'b010111; flags = 4'b1011;
    step("brc.decode", cb(2), 1'b0, 1'b0);
    step("brc.op", cb(3), 1'b0, 1'b0);
    step("brc.take", cb(18), 1'b0, 1'b0);
    step("brc.fetch", cb(1), 1'b0, 1'b0);

    $display("tx STR ra=0");
    op = 6'b000011; ra = 1'b0;
    step("str.decode", cb(2), 1'b0, 1'b0);
    step("str.op", cb(11), 1'b0, 1'b0);
    step("str.x", cb(12), 1'b0, 1'b0);
    step("str.fetch", cb(1), 1'b0, 1'b0);

    $display("tx STA #imm");
    op = 6'b000110;
    step("sai.decode", cb(2), 1'b0, 1'b0);
    step("sai.op", cb(11), 1'b0, 1'b0);
    step("sai.swr", cb(15), 1'b0, 1'b0);
    step("sai.fetch", cb(1), 1'b0, 1'b0);

    $display("tx illegal 111111");
    op = 6'b111111;
    step("ill.decode", cb(2), 1'b0, 1'b0);
    step("ill.idle", 19'd0, 1'b1, 1'b0);
    chk("ill.err", 32'(err), 32'd1);
    chk("ill.err_code", 32'(err_code), 32'd1);
    step("ill.sticky", 19'd0, 1'b1, 1'b0);
    chk("ill.sticky.err", 32'(err), 32'd1);

    $display("tx HLT clears error");
    op = 6'b000000; start = 1'b1;
    step("hlt.start", cb(0), 1'b0, 1'b0);
    start = 1'b0;
    chk("hlt.err_clr", 32'(err), 32'd0);
    chk("hlt.code_clr", 32'(err_code), 32'd0);
    step("hlt.fetch", cb(1), 1'b0, 1'b0);
    step("hlt.decode", cb(2), 1'b0, 1'b0);
    step("hlt.idle", 19'd0, 1'b1, 1'b0);
    chk("hlt.err", 32'(err), 32'd0);

`ifdef CU_ALU_TIMEOUT_EN
    $display("tx LDA offset timeout");
    op = 6'b000010; ra = 1'b0; start = 1'b1;
    step("to.start", cb(0), 1'b0, 1'b0);
    start = 1'b0;
    step("to.fetch", cb(1), 1'b0, 1'b0);
    step("to.decode", cb(2), 1'b0, 1'b0);
    step("to.la_x", cb(6), 1'b0, 1'b0);
    step("to.lagen", cb(8), 1'b0, 1'b1);
    chk("to.alu_op", 32'(alu_op), 32'd0);
    for (int i = 1; i <= 4; i++) step($sformatf("to.wait%0d", i), 19'd0, 1'b0, 1'b0);
    step("to.idle", 19'd0, 1'b1, 1'b0);
    chk("to.err", 32'(err), 32'd1);
    chk("to.err_code", 32'(err_code), 32'd2);
    op = 6'b000000; start = 1'b1;
    step("to.restart", cb(0), 1'b0, 1'b0);
    start = 1'b0;
    chk("to.err_clr", 32'(err), 32'd0);
    chk("to.code_clr", 32'(err_code), 32'd0);
    step("to.fetch2", cb(1), 1'b0, 1'b0);
    step("to.decode2", cb(2), 1'b0, 1'b0);
    step("to.idle2", 19'd0, 1'b1, 1'b0);
`else
    $display("tx LDA offset long wait");
    op = 6'b000010; ra = 1'b0; start = 1'b1;
    step("lw.start", cb(0), 1'b0, 1'b0);
    start = 1'b0;
    step("lw.fetch", cb(1), 1'b0, 1'b0);
    step("lw.decode", cb(2), 1'b0, 1'b0);
    step("lw.la_x", cb(6), 1'b0, 1'b0);
    step("lw.lagen", cb(8), 1'b0, 1'b1);
    chk("lw.alu_op", 32'(alu_op), 32'd0);
    for (int i = 1; i <= 6; i++) step($sformatf("lw.wait%0d", i), 19'd0, 1'b0, 1'b0);
    chk("lw.err", 32'(err), 32'd0);
    ack_alu = 1'b1;
    step("lw.lmem", cb(9), 1'b0, 1'b0);
    ack_alu = 1'b0;
    step("lw.lwb", cb(10), 1'b0, 1'b0);
    op = 6'b000000;
    step("lw.fetch2", cb(1), 1'b0, 1'b0);
    step("lw.decode2", cb(2), 1'b0, 1'b0);
    step("lw.idle", 19'd0, 1'b1, 1'b0);
`endif

    $display("tx reset during AWAIT");
    op = 6'b001101; start = 1'b1;
    step("rw.start", cb(0), 1'b0, 1'b0);
    start = 1'b0;
    step("rw.fetch", cb(1), 1'b0, 1'b0);
    step("rw.decode", cb(2), 1'b0, 1'b0);
    step("rw.aex", cb(16), 1'b0, 1'b1);
    chk("rw.aex.alu_op", 32'(alu_op), 32'd5);
    step("rw.wait", 19'd0, 1'b0, 1'b0);
    rst_b = 1'b0;
    step("rw.reset", 19'd0, 1'b1, 1'b0);
    chk("rw.alu_op", 32'(alu_op), 32'd0);
    chk("rw.err", 32'(err), 32'd0);
    chk("rw.err_code", 32'(err_code), 32'd0);
    rst_b = 1'b1; ack_alu = 1'b1;
    step("rw.ack_ignored", 19'd0, 1'b1, 1'b0);
    step("rw.ack_ignored2", 19'd0, 1'b1, 1'b0);
    ack_alu = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
